// File: rtl/eprisc_bus_pkg.sv
// Shared definitions for the epRISC memory-bus initiator: default widths and FSM state encoding.
package eprisc_bus_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RD_HOLD = 3'd4
    } state_t;

endpackage

// File: rtl/eprisc_bus_initiator.sv
// Bus master for the epRISC tri-state memory bus: single-beat writes and 1..16 beat
// incrementing reads, with read data returned on a valid/ready stream.
module eprisc_bus_initiator
    import eprisc_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic              iReqWrite,
    input  logic [ADDR_W-1:0] iReqAddr,
    input  logic [DATA_W-1:0] iReqData,
    input  logic [LEN_W-1:0]  iReqLen,
    output logic              oRspValid,
    input  logic              iRspReady,
    output logic [DATA_W-1:0] oRspData,
    output logic              oRspLast,
    output logic              oWrAck,
    output logic [ADDR_W-1:0] oAddr,
    inout  wire  [DATA_W-1:0] bData,
    output logic              oWrite,
    output logic              oEnable
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic                write_q, write_d;
    logic                enable_q, enable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_last_q, rsp_last_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                wr_ack_q, wr_ack_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        count_d     = count_q;
        write_d     = 1'b0;
        enable_d    = enable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;
        wr_ack_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (iReqValid) begin
                    addr_d = iReqAddr;
                    if (iReqWrite) begin
                        wr_data_d = iReqData;
                        write_d   = 1'b1;
                        state_d   = WR;
                    end else begin
                        count_d  = iReqLen;
                        enable_d = 1'b1;
                        state_d  = RD_ADDR;
                    end
                end
            end
            WR: begin
                // The responder has committed on the edge that ends this cycle.
                wr_ack_d = 1'b1;
                state_d  = IDLE;
            end
            RD_ADDR: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                rsp_data_d  = bData;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (count_q == '0);
                state_d     = RD_HOLD;
            end
            RD_HOLD: begin
                if (iRspReady) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (rsp_last_q) begin
                        enable_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        // Address wraps modulo 2^ADDR_W by construction.
                        addr_d  = addr_q + ADDR_W'(1);
                        count_d = count_q - LEN_W'(1);
                        state_d = RD_ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_data_q   <= '0;
            count_q     <= '0;
            write_q     <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            wr_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            count_q     <= count_d;
            write_q     <= write_d;
            enable_q    <= enable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    assign oReqReady = (state_q == IDLE) && !iRst;
    assign oRspValid = rsp_valid_q;
    assign oRspData  = rsp_data_q;
    assign oRspLast  = rsp_last_q;
    assign oWrAck    = wr_ack_q;
    assign oAddr     = addr_q;
    assign oWrite    = write_q;
    assign oEnable   = enable_q;

    assign bData = write_q ? wr_data_q : 'z;

endmodule

// File: tb/tb_eprisc_bus_initiator.sv
// Scoreboard bench for eprisc_bus_initiator with a ROM (0x00-0x0F) + RAM responder on the shared bus.
module tb_eprisc_bus_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_len = 4'h0;
    logic        rsp_ready = 1'b0;

    logic        oReqReady, oRspValid, oRspLast, oWrAck, oWrite, oEnable;
    logic [31:0] oRspData;
    logic [7:0]  oAddr;
    wire  [31:0] bData;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    eprisc_bus_initiator dut (
        .iClk      (clk),
        .iRst      (rst),
        .iReqValid (req_valid),
        .oReqReady (oReqReady),
        .iReqWrite (req_write),
        .iReqAddr  (req_addr),
        .iReqData  (req_data),
        .iReqLen   (req_len),
        .oRspValid (oRspValid),
        .iRspReady (rsp_ready),
        .oRspData  (oRspData),
        .oRspLast  (oRspLast),
        .oWrAck    (oWrAck),
        .oAddr     (oAddr),
        .bData     (bData),
        .oWrite    (oWrite),
        .oEnable   (oEnable)
    );

    // Image: ROM words below 0x10 (write-protected), RAM preloaded with 0xCAFE00xx.
    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h2441_3345;
            8'h01:   return 32'h2500_0000;
            8'h02:   return 32'h2600_0200;
            8'h03:   return 32'h2701_0001;
            default: return (a < 8'h10) ? (32'h2800_0000 | 32'(a)) : (32'hCAFE_0000 | 32'(a));
        endcase
    endfunction

    logic [31:0] ram [256];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(8'(i));
        end else if (oWrite && oAddr >= 8'h10) begin
            ram[oAddr] <= bData;
        end
        if (oEnable) rd_q <= ram[oAddr];
    end
    assign bData = (oEnable && !oWrite) ? rd_q : 'z;

    typedef struct {
        logic        is_ack;
        logic [31:0] data;
        logic        last;
        int          exp_cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [31:0] model [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle bus rules plus scoreboard pops on ack / response handshake.
    logic mon_en = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("no_x", 32'($isunknown({oReqReady, oRspValid, oRspData, oRspLast,
                                         oWrAck, oAddr, oWrite, oEnable})), 32'd0);
            chk("write_excl", 32'(oWrite && (oEnable || oRspValid || prev_wr)), 32'd0);
            chk("ack_rsp_excl", 32'(oWrAck && oRspValid), 32'd0);
            if (oEnable && !oWrite) chk("bus_data", bData, rd_q);
            if (oWrAck) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_kind", 32'(e.is_ack), 32'd1);
                    chk("ack_latency", cyc, e.exp_cyc);
                    $display("[TB] write ack at cycle %0d", cyc);
                end
            end
            if (oRspValid && !prev_valid && sb.size() > 0 && sb[0].exp_cyc >= 0)
                chk("rd_latency", cyc, sb[0].exp_cyc);
            if (oRspValid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_kind", 32'(e.is_ack), 32'd0);
                    chk("rsp_data", oRspData, e.data);
                    chk("rsp_last", 32'(oRspLast), 32'(e.last));
                    $display("[TB] read beat addr=%h data=%h last=%0d", oAddr, oRspData, oRspLast);
                end
            end
        end
        prev_valid <= oRspValid;
        prev_wr    <= oWrite;
    end

    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] len, output int acc);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        req_len   = len;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (oReqReady) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        // Scramble request fields: they must have no effect after acceptance.
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 8'h5A;
        req_data  = 32'h0BAD_0BAD;
        req_len   = 4'hF;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        int acc;
        exp_t x;
        issue(1'b1, a, d, 4'h0, acc);
        x.is_ack = 1'b1; x.data = 32'h0; x.last = 1'b0; x.exp_cyc = acc + 2;
        if (acc >= 0) sb.push_back(x);
        if (a >= 8'h10) model[a] = d;
        wait_drain();
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len,
                           input int hold_beat, input int hold_n);
        int acc;
        bit got;
        exp_t x;
        logic [7:0] ea;
        logic [7:0] ca;
        logic [31:0] cd;
        issue(1'b0, a, 32'h0, len, acc);
        if (acc < 0) return;
        for (int b = 0; b <= int'(len); b++) begin
            ea = a + 8'(b);
            x.is_ack = 1'b0; x.data = model[ea]; x.last = (b == int'(len));
            x.exp_cyc = (b == 0) ? acc + 3 : -1;
            sb.push_back(x);
        end
        for (int b = 0; b <= int'(len); b++) begin
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (oRspValid) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                chk("rsp_timeout", 32'd1, 32'd0);
                return;
            end
            ea = a + 8'(b);
            chk("rd_addr", 32'(oAddr), 32'(ea));
            if (b == hold_beat) begin
                cd = oRspData;
                ca = oAddr;
                for (int h = 0; h < hold_n; h++) begin
                    @(negedge clk);
                    chk("hold_data", oRspData, cd);
                    chk("hold_ctl", {21'b0, oRspValid, oWrite, oEnable, oAddr},
                                    {21'b0, 1'b1, 1'b0, 1'b1, ca});
                end
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input logic exp_ready);
        chk("rst_ctl", {18'b0, oAddr, oWrite, oEnable, oRspValid, oRspLast, oWrAck, oReqReady},
                       {18'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_ready});
        chk("rst_data", oRspData, 32'h0);
    endtask

    initial begin : stim
        int acc;
        bit got;
        for (int i = 0; i < 256; i++) model[i] = init_word(8'(i));

        @(negedge clk);
        chk_reset_outputs(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        preload = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(oReqReady), 32'd1);

        // ROM burst
        do_read(8'h00, 4'd3, -1, 0);
        // RAM write then read-back
        do_write(8'h10, 32'hDEAD_BEEF);
        do_read(8'h10, 4'd0, -1, 0);
        // ROM write is ignored by the responder
        do_write(8'h01, 32'h1111_1111);
        do_read(8'h01, 4'd0, -1, 0);
        // Address wrap FE,FF,00,01
        do_read(8'hFE, 4'd3, -1, 0);
        // Backpressure on beat 2
        do_write(8'h41, 32'h1234_5678);
        do_read(8'h40, 4'd3, 1, 5);

        // Reset while holding beat 1 of a 4-beat read
        issue(1'b0, 8'h20, 32'h0, 4'd3, acc);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (oRspValid) begin
                got = 1'b1;
                break;
            end
        end
        chk("t5_first_valid", 32'(got), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs(1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs(1'b1);
        $display("[TB] reset mid-burst, outputs cleared");

        // Recovery after reset
        do_read(8'h02, 4'd1, -1, 0);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
